// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA scan-out reads always win, pixel-writer writes fill the free cycles.
// Optional macro FB_BLANK_WRITE_EN restricts writer accepts to vertical blanking (tear-free updates).
module vga_fb_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [9:0]        cnt_h,
    input  logic [9:0]        cnt_v,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_valid,
    output logic              err_oob
);

    // state      | meaning
    // WAIT_FRAME | waiting for the first (0,0) pixel strobe; no display fetches
    // ACTIVE     | display fetches on every visible pixel strobe
    typedef enum logic {
        ST_WAIT_FRAME = 1'b0,
        ST_ACTIVE     = 1'b1
    } state_t;

    localparam logic [9:0]        H_LIM   = 10'(H_VISIBLE);
    localparam logic [9:0]        V_LIM   = 10'(V_VISIBLE);
    localparam logic [ADDR_W:0]   FB_SIZE = (ADDR_W+1)'(H_VISIBLE * V_VISIBLE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd1_v_q, rd1_v_d;
    logic                rd1_tag_q, rd1_tag_d;
    logic                rd2_v_q, rd2_v_d;
    logic                rd2_tag_q, rd2_tag_d;
    logic [DATA_W-1:0]   pix_rgb_q, pix_rgb_d;
    logic                pix_valid_q, pix_valid_d;
    logic                err_oob_q, err_oob_d;

    logic                visible;
    logic                disp_req;
    logic                wr_xfer;
    logic                wr_in_range;
    logic [ADDR_W-1:0]   fetch_addr;

    assign visible     = (cnt_h < H_LIM) && (cnt_v < V_LIM);
    assign disp_req    = (state_q == ST_ACTIVE) && pix_ce && visible;
    assign fetch_addr  = ADDR_W'(int'(cnt_v) * H_VISIBLE + int'(cnt_h));
    assign wr_in_range = {1'b0, wr_addr} < FB_SIZE;
    assign wr_xfer     = wr_valid && wr_ready;

`ifdef FB_BLANK_WRITE_EN
    logic blank_q, blank_d;

    // Writes are gated to vertical blanking so scan-out never shows a half-updated frame.
    assign wr_ready = !disp_req && blank_q;

    always_comb begin
        blank_d = blank_q;
        if (pix_ce) begin
            blank_d = (cnt_v >= V_LIM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 1'b1;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign wr_ready = !disp_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        err_oob_d   = err_oob_q;
        rd1_v_d     = (state_q == ST_ACTIVE) && pix_ce;
        rd1_tag_d   = visible;
        rd2_v_d     = rd1_v_q;
        rd2_tag_d   = rd1_tag_q;
        pix_rgb_d   = pix_rgb_q;
        pix_valid_d = pix_valid_q;

        if (state_q == ST_WAIT_FRAME && pix_ce && cnt_h == 10'd0 && cnt_v == 10'd0) begin
            state_d = ST_ACTIVE;
        end

        if (disp_req) begin
            mem_addr_d = fetch_addr;
        end else if (wr_xfer) begin
            if (wr_in_range) begin
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
                mem_we_d    = 1'b1;
            end else begin
                err_oob_d = 1'b1;
            end
        end

        // RAM data for the tagged fetch is present on mem_rdata during this cycle.
        if (rd2_v_q) begin
            pix_rgb_d   = rd2_tag_q ? mem_rdata : '0;
            pix_valid_d = rd2_tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_FRAME;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd1_v_q     <= 1'b0;
            rd1_tag_q   <= 1'b0;
            rd2_v_q     <= 1'b0;
            rd2_tag_q   <= 1'b0;
            pix_rgb_q   <= '0;
            pix_valid_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd1_v_q     <= rd1_v_d;
            rd1_tag_q   <= rd1_tag_d;
            rd2_v_q     <= rd2_v_d;
            rd2_tag_q   <= rd2_tag_d;
            pix_rgb_q   <= pix_rgb_d;
            pix_valid_q <= pix_valid_d;
            err_oob_q   <= err_oob_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_rgb   = pix_rgb_q;
    assign pix_valid = pix_valid_q;
    assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
    localparam int H    = 640;
    localparam int V    = 480;
    localparam int AW   = 19;
    localparam int DW   = 6;
    localparam int FBSZ = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_ce = 1'b0;
    logic [9:0]    cnt_h = '0;
    logic [9:0]    cnt_v = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_rgb;
    logic          pix_valid;
    logic          err_oob;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .cnt_h(cnt_h), .cnt_v(cnt_v),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_rgb(pix_rgb), .pix_valid(pix_valid), .err_oob(err_oob)
    );

    always #10 clk = ~clk;

    // Single-port synchronous RAM with a backdoor write port for preloading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          bk_we = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [DW-1:0] bk_data = '0;
    always @(posedge clk) begin
        if (bk_we) ram[bk_addr] <= bk_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int            due;
        logic [DW-1:0] rgb;
        logic          vld;
    } pix_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [DW-1:0] exp_fb [int];
    pix_t          pq [$];
    logic          m_active, m_err, m_blank, m_we, m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rgb;
    logic          pend_v;
    int            pend_a;
    logic [DW-1:0] pend_d;
    logic          exp_ready, act_ready;

    function automatic logic [DW-1:0] fb_val(input int a);
        if (exp_fb.exists(a)) return exp_fb[a];
        return '0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_err = 0; m_blank = 1; m_we = 0; m_valid = 0;
        m_addr = '0; m_wdata = '0; m_rgb = '0; pend_v = 0; pend_a = 0; pend_d = '0;
        pq.delete();
    endtask

    // Drives one clock cycle of inputs, predicts the post-edge outputs, and returns at the next negedge.
    task automatic tick(input logic pce, input int h, input int v, input logic wv,
                        input int wa, input logic [DW-1:0] wd);
        logic vis, disp, acc;
        int   fa;
        pix_t e;
        pix_ce = pce; cnt_h = 10'(h); cnt_v = 10'(v);
        wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
        #1;
        vis  = (h < H) && (v < V);
        disp = m_active && pce && vis;
        fa   = v * H + h;
        exp_ready = !disp;
`ifdef FB_BLANK_WRITE_EN
        exp_ready = exp_ready && m_blank;
`endif
        act_ready = wr_ready;
        acc = wv && exp_ready;
        if (m_active && pce) begin
            e.due = cyc + 3;
            e.vld = vis;
            e.rgb = !vis ? '0 : ((pend_v && pend_a == fa) ? pend_d : fb_val(fa));
            pq.push_back(e);
        end
        if (pend_v) exp_fb[pend_a] = pend_d;
        pend_v = 0;
        if (disp) begin
            m_addr = AW'(fa); m_we = 0;
        end else if (acc) begin
            if (wa < FBSZ) begin
                m_we = 1; m_addr = AW'(wa); m_wdata = wd;
                pend_v = 1; pend_a = wa; pend_d = wd;
            end else begin
                m_we = 0; m_err = 1;
            end
        end else begin
            m_we = 0;
        end
        if (pce && h == 0 && v == 0) m_active = 1;
        if (pce) m_blank = (v >= V);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        while (pq.size() > 0 && pq[0].due == cyc) begin
            e = pq.pop_front();
            m_rgb = e.rgb; m_valid = e.vld;
        end
    endtask

    task automatic idle();
        tick(1'b0, 0, 0, 1'b0, 0, '0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        wr_valid = 1'b0; pix_ce = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    task automatic preload();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 16; x++) begin
                bk_we = 1'b1; bk_addr = AW'(y * H + x); bk_data = DW'($urandom);
                exp_fb[y * H + x] = bk_data;
                @(posedge clk); @(negedge clk);
            end
        end
        bk_addr = AW'(641); bk_data = 6'b110000; exp_fb[641] = 6'b110000;
        @(posedge clk); @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b0, 0, 0, 1'b1, 5, 6'h2A);
        n_cmp++;
        if (mem_we !== 1'b1) begin n_err++; $display("FAIL rst_prewrite mem_we got %b exp 1", mem_we); end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_addr, mem_we, mem_wdata, pix_rgb, pix_valid, err_oob} !== '0) begin
            n_err++;
            $display("FAIL rst_async addr=%0d we=%b wdata=%h rgb=%h valid=%b oob=%b exp all 0",
                     mem_addr, mem_we, mem_wdata, pix_rgb, pix_valid, err_oob);
        end
        wr_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        tick(1'b1, 1, 1, 1'b0, 0, '0);
        idle();
        tick(1'b1, 3, 2, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            idle();
            n_cmp++;
            if (pix_rgb !== '0 || pix_valid !== 1'b0 || mem_addr !== '0) begin
                n_err++;
                $display("FAIL rst_waitframe rgb=%h valid=%b addr=%0d exp 0/0/0", pix_rgb, pix_valid, mem_addr);
            end
        end
    endtask

    task automatic test_fetch();
        tick(1'b1, 0, 0, 1'b0, 0, '0);
        idle();
        tick(1'b1, 1, 1, 1'b0, 0, '0);
        n_cmp++;
        if (mem_addr !== 19'd641 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL fetch_addr got %0d we=%b exp 641 we=0", mem_addr, mem_we);
        end
        idle();
        n_cmp++;
        if (pix_valid !== 1'b0) begin n_err++; $display("FAIL fetch_early valid got %b exp 0", pix_valid); end
        tick(1'b1, 5, 0, 1'b0, 0, '0);
        n_cmp++;
        if (pix_rgb !== 6'b110000 || pix_valid !== 1'b1) begin
            n_err++; $display("FAIL fetch_641 rgb=%b valid=%b exp 110000/1", pix_rgb, pix_valid);
        end
        idle();
        tick(1'b1, 700, 0, 1'b0, 0, '0);
        n_cmp++;
        if (pix_rgb !== m_rgb || pix_valid !== 1'b1) begin
            n_err++; $display("FAIL fetch_abandoned_write rgb=%h valid=%b exp %h/1", pix_rgb, pix_valid, m_rgb);
        end
        idle();
        idle();
        n_cmp++;
        if (pix_rgb !== '0 || pix_valid !== 1'b0) begin
            n_err++; $display("FAIL fetch_invisible rgb=%h valid=%b exp 0/0", pix_rgb, pix_valid);
        end
    endtask

    task automatic test_collision();
        int waits = 0;
        int pulses = 0;
        tick(1'b1, 2, 0, 1'b1, 100, 6'h15);
        n_cmp++;
        if (act_ready !== exp_ready) begin n_err++; $display("FAIL coll_ready0 got %b exp %b", act_ready, exp_ready); end
`ifndef FB_BLANK_WRITE_EN
        n_cmp++;
        if (act_ready !== 1'b0) begin n_err++; $display("FAIL coll_display_wins ready got %b exp 0", act_ready); end
`endif
        n_cmp++;
        if (mem_addr !== m_addr || mem_we !== 1'b0) begin
            n_err++; $display("FAIL coll_fetch addr=%0d we=%b exp %0d/0", mem_addr, mem_we, m_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 0, 0, 1'b1, 100, 6'h15);
            waits++;
            n_cmp++;
            if (act_ready !== exp_ready) begin n_err++; $display("FAIL coll_retry_ready got %b exp %b", act_ready, exp_ready); end
            if (mem_we === 1'b1) pulses++;
            if (exp_ready) break;
        end
        n_cmp++;
        if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
            n_err++; $display("FAIL coll_write we=%b addr=%0d data=%h exp %b/%0d/%h", mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata);
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            if (mem_we === 1'b1) pulses++;
        end
`ifndef FB_BLANK_WRITE_EN
        n_cmp++;
        if (waits != 1 || pulses != 1 || mem_addr !== 19'd100 || mem_wdata !== 6'h15) begin
            n_err++; $display("FAIL coll_single waits=%0d pulses=%0d addr=%0d data=%h exp 1/1/100/15", waits, pulses, mem_addr, mem_wdata);
        end
`endif
    endtask

    task automatic test_coherence();
        tick(1'b1, 0, 480, 1'b0, 0, '0);
        tick(1'b0, 0, 0, 1'b1, 0, 6'b000011);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 6'b000011) begin
            n_err++; $display("FAIL coh_write we=%b addr=%0d data=%b exp 1/0/000011", mem_we, mem_addr, mem_wdata);
        end
        tick(1'b1, 0, 0, 1'b0, 0, '0);
        idle();
        idle();
        n_cmp++;
        if (pix_rgb !== 6'b000011 || pix_valid !== 1'b1) begin
            n_err++; $display("FAIL coh_readback rgb=%b valid=%b exp 000011/1", pix_rgb, pix_valid);
        end
    endtask

    task automatic test_oob();
        logic [AW-1:0] held;
        tick(1'b1, 0, 480, 1'b0, 0, '0);
        held = mem_addr;
        tick(1'b0, 0, 0, 1'b1, 307200, 6'h3F);
        n_cmp++;
        if (act_ready !== 1'b1) begin n_err++; $display("FAIL oob_accept ready got %b exp 1", act_ready); end
        n_cmp++;
        if (mem_we !== 1'b0 || err_oob !== 1'b1 || mem_addr !== held) begin
            n_err++; $display("FAIL oob_drop we=%b oob=%b addr=%0d exp 0/1/%0d", mem_we, err_oob, mem_addr, held);
        end
        tick(1'b0, 0, 0, 1'b1, 7, 6'h09);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd7 || err_oob !== 1'b1) begin
            n_err++; $display("FAIL oob_sticky we=%b addr=%0d oob=%b exp 1/7/1", mem_we, mem_addr, err_oob);
        end
        for (int i = 0; i < 3; i++) idle();
        n_cmp++;
        if (err_oob !== 1'b1) begin n_err++; $display("FAIL oob_hold got %b exp 1", err_oob); end
        do_reset();
        n_cmp++;
        if (err_oob !== 1'b0) begin n_err++; $display("FAIL oob_clear got %b exp 0", err_oob); end
    endtask

`ifdef FB_BLANK_WRITE_EN
    task automatic test_blank();
        int lines [6] = '{1, 2, 100, 250, 478, 479};
        tick(1'b1, 0, 0, 1'b0, 0, '0);
        idle();
        tick(1'b1, 3, 0, 1'b1, 200, 6'h2B);
        n_cmp++;
        if (act_ready !== 1'b0) begin n_err++; $display("FAIL blank_line0 ready got %b exp 0", act_ready); end
        idle_w: for (int i = 0; i < 6; i++) begin
            tick(1'b0, 0, 0, 1'b1, 200, 6'h2B);
            n_cmp++;
            if (act_ready !== 1'b0) begin n_err++; $display("FAIL blank_hold line=%0d ready got %b exp 0", lines[i], act_ready); end
            tick(1'b1, 650, lines[i], 1'b1, 200, 6'h2B);
            n_cmp++;
            if (act_ready !== 1'b0) begin n_err++; $display("FAIL blank_pce line=%0d ready got %b exp 0", lines[i], act_ready); end
        end
        tick(1'b0, 0, 0, 1'b1, 200, 6'h2B);
        tick(1'b1, 0, 480, 1'b1, 200, 6'h2B);
        n_cmp++;
        if (act_ready !== 1'b0) begin n_err++; $display("FAIL blank_480_same ready got %b exp 0", act_ready); end
        tick(1'b0, 0, 0, 1'b1, 200, 6'h2B);
        n_cmp++;
        if (act_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd200) begin
            n_err++; $display("FAIL blank_first_accept ready=%b we=%b addr=%0d exp 1/1/200", act_ready, mem_we, mem_addr);
        end
        idle();
    endtask
`endif

    task automatic test_random();
        logic          busy = 0;
        logic          pce;
        int            wa = 0;
        logic [DW-1:0] wd = '0;
        int            h, v, r;
        tick(1'b1, 0, 0, 1'b0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            pce = (i % 2) == 1;
            h = 0; v = 0;
            if (pce) begin
                r = $urandom_range(0, 9);
                if (r < 6) begin h = $urandom_range(0, 15); v = $urandom_range(0, 3); end
                else if (r < 8) begin h = $urandom_range(640, 799); v = $urandom_range(0, 524); end
                else begin h = $urandom_range(0, 799); v = $urandom_range(480, 524); end
            end
            if (!busy && $urandom_range(0, 1) == 1) begin
                busy = 1;
                r = $urandom_range(0, 19);
                if (r < 16) wa = $urandom_range(0, 3) * H + $urandom_range(0, 15);
                else if (r < 19) wa = $urandom_range(0, FBSZ - 1);
                else wa = $urandom_range(FBSZ, (1 << AW) - 1);
                wd = DW'($urandom);
            end
            tick(pce, h, v, busy, wa, wd);
            if (busy && exp_ready) busy = 0;
            n_cmp++;
            if (act_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, act_ready, exp_ready); end
            n_cmp++;
            if (mem_we !== m_we) begin n_err++; $display("FAIL rnd_we cyc=%0d got %b exp %b", cyc, mem_we, m_we); end
            n_cmp++;
            if (mem_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got %0d exp %0d", cyc, mem_addr, m_addr); end
            n_cmp++;
            if (mem_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_wdata cyc=%0d got %h exp %h", cyc, mem_wdata, m_wdata); end
            n_cmp++;
            if (err_oob !== m_err) begin n_err++; $display("FAIL rnd_oob cyc=%0d got %b exp %b", cyc, err_oob, m_err); end
            n_cmp++;
            if (pix_rgb !== m_rgb || pix_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_pix cyc=%0d got %h/%b exp %h/%b", cyc, pix_rgb, pix_valid, m_rgb, m_valid);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        preload();
        rst = 1'b0;
        test_reset();
        test_fetch();
        test_collision();
        test_coherence();
        test_oob();
`ifdef FB_BLANK_WRITE_EN
        test_blank();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
